// File: rtl/ib_mailbox_if.sv
// Mailbox bus between the port-expander decode / UART byte FIFOs and ib_mailbox_ctrl.
// master = MCU ports and FIFO side; slave = the mailbox controller.
interface ib_mailbox_if;
    logic [3:0] p7_ctrl;
    logic [3:0] p4_wr;
    logic [3:0] p5_wr;
    logic [3:0] p4_rd;
    logic [3:0] p5_rd;
    logic [3:0] p6_stat;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output p7_ctrl, p4_wr, p5_wr, rx_data, rx_valid, tx_ready,
        input  p4_rd, p5_rd, p6_stat, rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  p7_ctrl, p4_wr, p5_wr, rx_data, rx_valid, tx_ready,
        output p4_rd, p5_rd, p6_stat, rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/ib_mailbox_ctrl.sv
// Byte mailbox sequencer: RX bytes out as nibbles with ready/complete handshake, MCU nibble pairs into TX bytes.
// Optional handshake stall timeout enabled by defining IB_MBOX_TIMEOUT_EN.
module ib_mailbox_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 8_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    ib_mailbox_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_PRESENT,
        RD_RELEASE,
        WR_PUSH,
        WR_ACK
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] rd_byte_q, rd_byte_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       rd_rdy_n_q, rd_rdy_n_d;
    logic       wr_ack_n_q, wr_ack_n_d;
    logic       rx_pend_q, rx_pend_d;
    logic       rx_ready_q, rx_ready_d;
    logic       tx_valid_q, tx_valid_d;
    logic       timeout_err_q;
    logic       timeout_hit;

    logic mode_wr, rd_complete_n, wr_avail_n;
    assign mode_wr       = bus.p7_ctrl[0];
    assign rd_complete_n = bus.p7_ctrl[1];
    assign wr_avail_n    = bus.p7_ctrl[2];

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("ib_mailbox_ctrl: TIMEOUT_CYC must be at least 2");
    end

`ifdef IB_MBOX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] tmo_cnt_q;

    assign timeout_hit = (state_q != IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Clear has priority over a timeout landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (!bus.p7_ctrl[3]) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.p7_ctrl[3];
    assign timeout_hit    = 1'b0;
    assign timeout_err_q  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_byte_q  <= '0;
            tx_data_q  <= '0;
            rd_rdy_n_q <= 1'b1;
            wr_ack_n_q <= 1'b1;
            rx_pend_q  <= 1'b0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_byte_q  <= rd_byte_d;
            tx_data_q  <= tx_data_d;
            rd_rdy_n_q <= rd_rdy_n_d;
            wr_ack_n_q <= wr_ack_n_d;
            rx_pend_q  <= rx_pend_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Mode is only looked at in IDLE; a started handshake always runs to completion.
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!mode_wr && bus.rx_valid) begin
                        state_d = RD_PRESENT;
                    end else if (mode_wr && !wr_avail_n) begin
                        state_d = WR_PUSH;
                    end
                end
                RD_PRESENT: if (!rd_complete_n) state_d = RD_RELEASE;
                RD_RELEASE: if (rd_complete_n)  state_d = IDLE;
                WR_PUSH:    if (bus.tx_ready)   state_d = WR_ACK;
                WR_ACK:     if (wr_avail_n)     state_d = IDLE;
                default:                        state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_byte_d  = rd_byte_q;
        tx_data_d  = tx_data_q;
        rd_rdy_n_d = rd_rdy_n_q;
        wr_ack_n_d = wr_ack_n_q;
        tx_valid_d = tx_valid_q;
        rx_ready_d = 1'b0;
        rx_pend_d  = (state_d != IDLE) && bus.rx_valid;
        if (timeout_hit) begin
            rd_rdy_n_d = 1'b1;
            wr_ack_n_d = 1'b1;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_d == RD_PRESENT) begin
                        rd_byte_d  = bus.rx_data;
                        rd_rdy_n_d = 1'b0;
                        rx_ready_d = 1'b1;
                    end else if (state_d == WR_PUSH) begin
                        tx_data_d  = {bus.p5_wr, bus.p4_wr};
                        tx_valid_d = 1'b1;
                    end
                end
                RD_PRESENT: if (state_d == RD_RELEASE) rd_rdy_n_d = 1'b1;
                WR_PUSH: begin
                    if (state_d == WR_ACK) begin
                        tx_valid_d = 1'b0;
                        wr_ack_n_d = 1'b0;
                    end
                end
                WR_ACK: if (state_d == IDLE) wr_ack_n_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.p4_rd    = rd_byte_q[3:0];
    assign bus.p5_rd    = rd_byte_q[7:4];
    assign bus.p6_stat  = {wr_ack_n_q, timeout_err_q, rx_pend_q, rd_rdy_n_q};
    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_ib_mailbox_ctrl.sv
// Bench for ib_mailbox_ctrl: queue-based RX FIFO / TX sink and an ordered-byte reference.
// Covers IB_MBOX_TIMEOUT_EN both ways via the same `ifdef.
`timescale 1ns/1ps
module tb_ib_mailbox_ctrl;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ib_mailbox_if bus();

    ib_mailbox_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int pop_cnt = 0;
    byte unsigned fifo_q[$];   // RX FIFO contents seen by the DUT
    byte unsigned exp_rx[$];   // bytes the MCU should see, in order
    byte unsigned tx_log[$];

    always @(posedge clk) begin
        if (bus.rx_ready === 1'b1) begin
            pop_cnt++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) tx_log.push_back(bus.tx_data);
    end

    always @(negedge clk) begin
        bus.rx_valid = (fifo_q.size() != 0);
        bus.rx_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rx(input byte unsigned b);
        fifo_q.push_back(b);
        exp_rx.push_back(b);
    endtask

    task automatic wait_present(input string tag);
        int n;
        n = 0;
        while (bus.p6_stat[0] !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check({tag, " present"}, 32'(bus.p6_stat[0]), 0);
    endtask

    task automatic read_handshake(input string tag, input int pops0);
        byte unsigned exp_b;
        logic exp_pend;
        bus.p7_ctrl = 4'b1110;
        wait_present(tag);
        exp_b = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
        exp_pend = (exp_rx.size() != 0);
        tick(3);
        check({tag, " data"}, {bus.p5_rd, bus.p4_rd}, exp_b);
        check({tag, " pending"}, 32'(bus.p6_stat[1]), 32'(exp_pend));
        bus.p7_ctrl = 4'b1100;
        tick();
        check({tag, " released"}, 32'(bus.p6_stat[0]), 1);
        check({tag, " hold"}, {bus.p5_rd, bus.p4_rd}, exp_b);
        bus.p7_ctrl = 4'b1110;
        tick();
        check({tag, " pops"}, pop_cnt - pops0, 1);
    endtask

    task automatic write_byte(input string tag, input logic [3:0] lo, input logic [3:0] hi,
                              input int stall);
        byte unsigned exp_b;
        int n0;
        exp_b = {hi, lo};
        n0 = tx_log.size();
        bus.p4_wr = lo;
        bus.p5_wr = hi;
        bus.p7_ctrl = 4'b1111;
        tick();
        bus.p7_ctrl = 4'b1011;
        tick();
        check({tag, " tx_valid"}, 32'(bus.tx_valid), 1);
        check({tag, " tx_data"}, 32'(bus.tx_data), 32'(exp_b));
        repeat (stall) begin
            tick();
            check({tag, " stall valid"}, 32'(bus.tx_valid), 1);
            check({tag, " stall ack_n"}, 32'(bus.p6_stat[3]), 1);
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check({tag, " tx_valid off"}, 32'(bus.tx_valid), 0);
        check({tag, " ack_n low"}, 32'(bus.p6_stat[3]), 0);
        check({tag, " push count"}, tx_log.size() - n0, 1);
        check({tag, " pushed byte"}, (tx_log.size() != 0) ? 32'(tx_log[$]) : 32'hFFFF, 32'(exp_b));
        bus.p7_ctrl = 4'b1111;
        tick();
        check({tag, " ack_n high"}, 32'(bus.p6_stat[3]), 1);
    endtask

    initial begin
        int pops0;
        byte unsigned b;
        bus.p7_ctrl  = 4'b1111;
        bus.p4_wr    = 4'h0;
        bus.p5_wr    = 4'h0;
        bus.tx_ready = 1'b0;

        // Reset state
        #12;
        check("rst p6", 32'(bus.p6_stat), 32'h9);
        check("rst p4", 32'(bus.p4_rd), 0);
        check("rst p5", 32'(bus.p5_rd), 0);
        check("rst rx_ready", 32'(bus.rx_ready), 0);
        check("rst tx_valid", 32'(bus.tx_valid), 0);
        check("rst tx_data", 32'(bus.tx_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed read stream, with first-byte latency and single pop pulse
        bus.p7_ctrl = 4'b1110;
        tick();
        pops0 = pop_cnt;
        push_rx(8'hDE);
        push_rx(8'hAD);
        push_rx(8'hBE);
        push_rx(8'hEF);
        tick();
        check("lat rd_rdy_n", 32'(bus.p6_stat[0]), 0);
        check("lat data", {bus.p5_rd, bus.p4_rd}, 32'hDE);
        check("lat rx_ready", 32'(bus.rx_ready), 1);
        tick();
        check("lat rx_ready pulse", 32'(bus.rx_ready), 0);
        read_handshake("rd0", pops0);
        read_handshake("rd1", pop_cnt);
        read_handshake("rd2", pop_cnt);
        read_handshake("rd3", pop_cnt);

        // Random read bytes
        for (int i = 0; i < 4; i++) push_rx(8'($urandom));
        for (int i = 0; i < 4; i++) read_handshake("rdr", pop_cnt);

        // Directed write with backpressure, then random writes
        write_byte("wr44", 4'h4, 4'h4, 5);
        for (int i = 0; i < 4; i++)
            write_byte("wrr", 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

        // Write mode must never pop, then read mode pops at once
        bus.p7_ctrl = 4'b1111;
        tick();
        b = 8'($urandom);
        push_rx(b);
        pops0 = pop_cnt;
        tick(100);
        check("guard pops", pop_cnt - pops0, 0);
        check("guard rd_rdy_n", 32'(bus.p6_stat[0]), 1);
        bus.p7_ctrl = 4'b1110;
        tick();
        check("guard rx_ready", 32'(bus.rx_ready), 1);
        check("guard data", {bus.p5_rd, bus.p4_rd}, 32'(b));
        read_handshake("guard", pops0);

        // Stalled read handshake
        b = 8'($urandom);
        push_rx(b);
        bus.p7_ctrl = 4'b1110;
        wait_present("stall");
        void'(exp_rx.pop_front());
`ifdef IB_MBOX_TIMEOUT_EN
        tick(TMO - 1);
        check("tmo not yet", 32'(bus.p6_stat[0]), 0);
        tick();
        check("tmo p6", 32'(bus.p6_stat), 32'hD);
        check("tmo byte kept", {bus.p5_rd, bus.p4_rd}, 32'(b));
        bus.p7_ctrl = 4'b0110;
        tick();
        check("tmo clear", 32'(bus.p6_stat[2]), 0);
        bus.p7_ctrl = 4'b1110;
        tick();
`else
        tick(1000);
        check("no tmo present", 32'(bus.p6_stat[0]), 0);
        check("no tmo err", 32'(bus.p6_stat[2]), 0);
        bus.p7_ctrl = 4'b1100;
        tick();
        bus.p7_ctrl = 4'b1110;
        tick();
`endif

        // Asynchronous reset withdraws a pending push
        bus.p4_wr = 4'($urandom);
        bus.p5_wr = 4'($urandom);
        bus.p7_ctrl = 4'b1011;
        tick(2);
        check("rstw tx_valid before", 32'(bus.tx_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw tx_valid", 32'(bus.tx_valid), 0);
        check("rstw p6", 32'(bus.p6_stat), 32'h9);
        check("rstw rx_ready", 32'(bus.rx_ready), 0);
        bus.p7_ctrl = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in RD_PRESENT loses the popped byte; the next one follows
        push_rx(8'($urandom));
        push_rx(8'($urandom));
        bus.p7_ctrl = 4'b1110;
        wait_present("rstr");
        tick(2);
        void'(exp_rx.pop_front());
        #2;
        rst_n = 1'b0;
        #1;
        check("rstr p6", 32'(bus.p6_stat), 32'h9);
        check("rstr p4p5", {bus.p5_rd, bus.p4_rd}, 0);
        check("rstr rx_ready", 32'(bus.rx_ready), 0);
        tick();
        rst_n = 1'b1;
        read_handshake("rstr next", pop_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
